simple_circuit_arbiter: RTL

Round-robin scheduler that shares one instance of the two-stage A/B/C logic pipeline (x = (A & B) | ~C, y = ~C, two-cycle latency) among NREQ requesters. Each cycle it grants at most one pending request, issues that requester's operands into the pipeline, and tags the issue so the result leaves two cycles later carrying the originating requester ID. It sits between the requesting front-end blocks and the shared pipeline and owns the pipeline registers.

---
 rtl/simple_circuit_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/simple_circuit_arbiter.sv
// Round-robin arbiter feeding a shared two-stage x=(A&B)|~C, y=~C pipeline; results return tagged with the requester ID.
// Optional SIMPLE_ARB_STATS_EN adds an issue counter and a registered conflict flag.
module simple_circuit_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op_a,
  input  logic [NREQ-1:0] op_b,
  input  logic [NREQ-1:0] op_c,
  input  logic            hold,
  output logic [NREQ-1:0] gnt,
  output logic            resp_valid,
  output logic [IDW-1:0]  resp_id,
  output logic            resp_x,
  output logic            resp_y,
  output logic            busy
`ifdef SIMPLE_ARB_STATS_EN
  ,
  output logic [15:0]     issue_cnt,
  output logic            conflict
`endif
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [IDW:0] pick_first(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (r[IDW'(idx)]) begin
        res = {1'b1, IDW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           v1_q, v1_d;
  logic [IDW-1:0] id1_q, id1_d;
  logic           e1_q, e1_d;
  logic           n1_q, n1_d;
  logic           resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic           resp_x_q, resp_y_q;
  logic [IDW:0]   pick_s;
  logic           grant_s;
  logic [IDW-1:0] gidx_s;

  // Grant selection, pointer advance and stage-1 capture values.
  always_comb begin
    pick_s  = pick_first(req, ptr_q);
    grant_s = pick_s[IDW] & ~hold;
    gidx_s  = pick_s[IDW-1:0];
    gnt     = '0;
    ptr_d   = ptr_q;
    v1_d    = grant_s;
    id1_d   = id1_q;
    e1_d    = e1_q;
    n1_d    = n1_q;
    if (grant_s) begin
      gnt   = ONE_HOT0 << gidx_s;
      id1_d = gidx_s;
      e1_d  = op_a[gidx_s] & op_b[gidx_s];
      n1_d  = ~op_c[gidx_s];
      if (gidx_s == IDW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gidx_s + {{(IDW-1){1'b0}}, 1'b1};
      end
    end else begin
      gnt = '0;
    end
  end

  // Pointer, stage-1 and stage-2 pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      v1_q         <= 1'b0;
      id1_q        <= '0;
      e1_q         <= 1'b0;
      n1_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_x_q     <= 1'b0;
      resp_y_q     <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      v1_q         <= v1_d;
      id1_q        <= id1_d;
      e1_q         <= e1_d;
      n1_q         <= n1_d;
      resp_valid_q <= v1_q;
      resp_id_q    <= id1_q;
      resp_x_q     <= e1_q | n1_q;
      resp_y_q     <= n1_q;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_x     = resp_x_q;
  assign resp_y     = resp_y_q;
  assign busy       = v1_q | resp_valid_q;

`ifdef SIMPLE_ARB_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic        conflict_q, conflict_d;
  logic        multi_s;

  // More than one requester pending at a grant edge counts as a conflict.
  always_comb begin
    multi_s     = |(req & (req - ONE_HOT0));
    issue_cnt_d = issue_cnt_q;
    if (grant_s) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end else begin
      issue_cnt_d = issue_cnt_q;
    end
    conflict_d = grant_s & multi_s;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= 16'd0;
      conflict_q  <= 1'b0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      conflict_q  <= conflict_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign conflict  = conflict_q;
`endif

endmodule
